// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined compare unit: condition codes,
// the per-slice compare bundle and the final condition selector.
package cmp_pkg;

  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LTU = 3'd2;
  localparam logic [2:0] CMP_LT  = 3'd3;
  localparam logic [2:0] CMP_GTU = 3'd4;
  localparam logic [2:0] CMP_GT  = 3'd5;
  localparam logic [2:0] CMP_GEU = 3'd6;
  localparam logic [2:0] CMP_GE  = 3'd7;

  // Result of comparing one operand slice.
  typedef struct packed {
    logic eq;   // slices equal
    logic ltu;  // a < b, unsigned
    logic lts;  // a < b, signed (only meaningful for the top slice)
  } slice_res_t;

  // Pick the flag for a condition code from the full-width relations.
  function automatic logic cmp_select(input logic [2:0] sel,
                                      input logic       eq,
                                      input logic       ltu,
                                      input logic       lt);
    logic gtu;
    logic gt;
    logic res;
    gtu = !ltu && !eq;
    gt  = !lt && !eq;
    case (sel)
      CMP_EQ:  res = eq;
      CMP_NE:  res = !eq;
      CMP_LTU: res = ltu;
      CMP_LT:  res = lt;
      CMP_GTU: res = gtu;
      CMP_GT:  res = gt;
      CMP_GEU: res = !ltu;
      CMP_GE:  res = !lt;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_slice.sv
// Compares one slice of the operands: equality, unsigned and signed less-than.
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  output slice_res_t    res_o
);

  // Plain magnitude compares on a half-width slice keep the chain short.
  always_comb begin
    res_o.eq  = (a_i == b_i);
    res_o.ltu = (a_i < b_i);
    res_o.lts = ($signed(a_i) < $signed(b_i));
  end

endmodule

// File: rtl/pipelined_compare_unit.sv
// Two-stage compare: slice compares into S1, combine and select into S2.
// Valid/ready on both sides, tag passthrough, flush kills in-flight work.
module pipelined_compare_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             flag,
  output logic [TAG_W-1:0] tag_out
);

  localparam int H = WIDTH / 2;

  slice_res_t hi_res_s;
  slice_res_t lo_res_s;
  logic       unused_lo_lts_s;

  // Lower slice is always unsigned; its signed result is not needed.
  assign unused_lo_lts_s = lo_res_s.lts;

  cmp_slice #(.SW(WIDTH - H)) u_slice_hi (
    .a_i   (a[WIDTH-1:H]),
    .b_i   (b[WIDTH-1:H]),
    .res_o (hi_res_s)
  );

  cmp_slice #(.SW(H)) u_slice_lo (
    .a_i   (a[H-1:0]),
    .b_i   (b[H-1:0]),
    .res_o (lo_res_s)
  );

  // Stage registers
  logic             s1_valid_q, s1_valid_d;
  slice_res_t       s1_hi_q, s1_hi_d;
  logic             s1_eq_lo_q, s1_eq_lo_d;
  logic             s1_ltu_lo_q, s1_ltu_lo_d;
  logic [2:0]       s1_sel_q, s1_sel_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_flag_q, s2_flag_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

  logic s2_adv_s;
  logic s1_adv_s;
  logic eq_s, ltu_s, lt_s;

  assign s2_adv_s  = !s2_valid_q || out_ready;
  assign s1_adv_s  = !s1_valid_q || s2_adv_s;
  assign in_ready  = s1_adv_s && !flush;
  assign out_valid = s2_valid_q;
  assign flag      = s2_flag_q;
  assign tag_out   = s2_tag_q;

  // Merge the two slice results into full-width relations.
  always_comb begin
    eq_s  = s1_hi_q.eq & s1_eq_lo_q;
    ltu_s = s1_hi_q.ltu | (s1_hi_q.eq & s1_ltu_lo_q);
    lt_s  = s1_hi_q.lts | (s1_hi_q.eq & s1_ltu_lo_q);
  end

  // S1 next state: accept a request when advancing; flush empties it.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hi_d     = s1_hi_q;
    s1_eq_lo_d  = s1_eq_lo_q;
    s1_ltu_lo_d = s1_ltu_lo_q;
    s1_sel_d    = s1_sel_q;
    s1_tag_d    = s1_tag_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_d = in_valid;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s1_adv_s && in_valid) begin
      s1_hi_d     = hi_res_s;
      s1_eq_lo_d  = lo_res_s.eq;
      s1_ltu_lo_d = lo_res_s.ltu;
      s1_sel_d    = sel;
      s1_tag_d    = tag_in;
    end else begin
      s1_hi_d     = s1_hi_q;
      s1_eq_lo_d  = s1_eq_lo_q;
      s1_ltu_lo_d = s1_ltu_lo_q;
      s1_sel_d    = s1_sel_q;
      s1_tag_d    = s1_tag_q;
    end
  end

  // S2 next state: take the selected flag from S1 when the output frees up.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_flag_d  = s2_flag_q;
    s2_tag_d   = s2_tag_q;
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (s2_adv_s && s1_valid_q) begin
      s2_flag_d = cmp_select(s1_sel_q, eq_s, ltu_s, lt_s);
      s2_tag_d  = s1_tag_q;
    end else begin
      s2_flag_d = s2_flag_q;
      s2_tag_d  = s2_tag_q;
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_hi_q     <= '0;
      s1_eq_lo_q  <= 1'b0;
      s1_ltu_lo_q <= 1'b0;
      s1_sel_q    <= 3'd0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_flag_q   <= 1'b0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hi_q     <= s1_hi_d;
      s1_eq_lo_q  <= s1_eq_lo_d;
      s1_ltu_lo_q <= s1_ltu_lo_d;
      s1_sel_q    <= s1_sel_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_flag_q   <= s2_flag_d;
      s2_tag_q    <= s2_tag_d;
    end
  end

endmodule
